// File: rtl/axi_memory_slave.sv
// axi_memory_slave
//   AXI4 memory responder backed by an internal word-addressed RAM.
//   Write and read paths are independent FSMs, each with one outstanding burst.
//
//   Optional feature macro: AXI_MEM_SLAVE_ERR_CHECK_EN
//     defined   - WRAP/reserved bursts, oversize beats, out-of-range beat
//                 addresses and wlast mismatches return SLVERR; erroring
//                 write beats leave the RAM alone, erroring read beats return 0.
//     undefined - responses are always OKAY, addresses wrap modulo the RAM,
//                 WRAP/reserved bursts behave as INCR, wlast/size unchecked.
//
//   Ports
//     clk, reset                         clock, async active-high reset
//     aw* / awready                      write address channel
//     w*  / wready                       write data channel
//     bid, bresp, bvalid / bready        write response channel
//     ar* / arready                      read address channel
//     rid, rdata, rresp, rlast, rvalid / rready   read data channel
//
//   Write FSM
//     state  | meaning
//     W_IDLE | awready high, waiting for a write address
//     W_DATA | wready high, accepting beats until the counter reaches len
//     W_RESP | bvalid high with stable bid/bresp until bready
//
//   Read FSM
//     state  | meaning
//     R_IDLE | arready high, waiting for a read address
//     R_DATA | rvalid high, one beat per rready, leaves after the rlast beat

module axi_memory_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,

  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,

  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,

  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,

  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // FIXED holds the address; every other burst type advances by the beat size
  // (WRAP only reaches here unchecked, where it is treated as INCR).
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0]            s,
                                                      input logic [1:0]            b);
    if (b == BURST_FIXED) return a;
    return a + (ADDR_WIDTH'(1) << s);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[LANE_W +: IDX_W];
  endfunction

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_t              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic [7:0]            w_cnt;
  logic                  w_err;
  logic                  w_last_beat;
  logic                  w_beat_err;
  logic                  aw_hs;
  logic                  w_hs;

  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign w_last_beat = (w_cnt == w_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        // burst length comes from the counter, never from wlast
        if (wvalid && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= awid;
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_size  <= awsize;
      w_burst <= awburst;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr  <= next_addr(w_addr, w_size, w_burst);
      w_cnt   <= w_cnt + 8'd1;
      w_err   <= w_err | w_beat_err;
    end
  end

  assign bid   = w_id;
  assign bresp = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

  // RAM is not reset; wready is low during reset so no beat can land then.
  always_ff @(posedge clk) begin
    if (w_hs && !w_beat_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_t              r_state, r_next;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [7:0]            r_cnt;
  logic                  r_err;
  logic                  ar_err;
  logic                  r_next_err;
  logic                  ar_hs;
  logic                  r_hs;

  assign ar_hs       = arvalid && arready;
  assign r_hs        = rvalid && rready;
  assign r_next_addr = next_addr(r_addr, r_size, r_burst);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    rlast   = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (r_cnt == r_len);
        if (rready && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // rdata is registered one beat ahead: the AR handshake fetches beat 0 and
  // every non-final R handshake fetches the following beat. Reading the RAM
  // with a nonblocking update gives old data on a same-edge write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      rdata   <= '0;
    end else if (ar_hs) begin
      r_id    <= arid;
      r_addr  <= araddr;
      r_len   <= arlen;
      r_size  <= arsize;
      r_burst <= arburst;
      r_cnt   <= '0;
      r_err   <= ar_err;
      rdata   <= ar_err ? '0 : mem[word_idx(araddr)];
    end else if (r_hs && !rlast) begin
      r_addr  <= r_next_addr;
      r_cnt   <= r_cnt + 8'd1;
      r_err   <= r_next_err;
      rdata   <= r_next_err ? '0 : mem[word_idx(r_next_addr)];
    end
  end

  assign rid   = r_id;
  assign rresp = r_err ? RESP_SLVERR : RESP_OKAY;

  // ---------------------------------------------------------------------------
  // Error detection
  // ---------------------------------------------------------------------------
`ifdef AXI_MEM_SLAVE_ERR_CHECK_EN
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = AW1'(MEM_DEPTH * BYTES);

  // burst[1] set covers both WRAP and the reserved encoding
  function automatic logic beat_bad(input logic [ADDR_WIDTH-1:0] a,
                                    input logic [2:0]            s,
                                    input logic [1:0]            b);
    return b[1] || (s > 3'(LANE_W)) || ({1'b0, a} >= MEM_BYTES);
  endfunction

  assign w_beat_err = beat_bad(w_addr, w_size, w_burst) || (wlast != w_last_beat);
  assign ar_err     = beat_bad(araddr, arsize, arburst);
  assign r_next_err = beat_bad(r_next_addr, r_size, r_burst);
`else
  logic unused_wlast;

  assign w_beat_err   = 1'b0;
  assign ar_err       = 1'b0;
  assign r_next_err   = 1'b0;
  assign unused_wlast = wlast;
`endif

endmodule

// File: tb/tb_axi_memory_slave.sv
module tb_axi_memory_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int DEPTH = 256;
`ifdef AXI_MEM_SLAVE_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  axi_memory_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array of words, byte-lane updates by strobe.
  logic [31:0] model_mem [DEPTH];
  logic [31:0] wbuf_data [256];
  logic [3:0]  wbuf_strb [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timed_out(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [1:0] burst,
                                            input int i);
    return (burst == 2'b00) ? start : start + 32'(i) * 32'd4;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit beat_err(input logic [31:0] a, input logic [1:0] burst);
    return ERR_EN && (burst[1] || a >= 32'(DEPTH * 4));
  endfunction

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int bdelay, input bit gaps);
    int n;
    bit err;
    logic [31:0] a;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) timed_out("aw_wait");
    tick();
    awvalid = 1'b0;
    chk("wready_after_aw", wready, 1);
    err = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin wvalid = 1'b0; tick(); end
      end
      wvalid = 1'b1; wdata = wbuf_data[i]; wstrb = wbuf_strb[i]; wlast = (i == len);
      a = beat_addr(addr, burst, i);
      if (beat_err(a, burst)) err = 1'b1;
      else begin
        for (int b = 0; b < 4; b++)
          if (wbuf_strb[i][b]) model_mem[widx(a)][b*8 +: 8] = wbuf_data[i][b*8 +: 8];
      end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_after_last", bvalid, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, err ? 2'b10 : 2'b00);
    for (int d = 0; d < bdelay; d++) begin
      tick();
      chk("bvalid_hold", bvalid, 1);
      chk("bid_hold", bid, id);
      chk("bresp_hold", bresp, err ? 2'b10 : 2'b00);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_drop", bvalid, 0);
    chk("awready_idle", awready, 1);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input bit rand_ready);
    int n;
    int i;
    logic [31:0] a;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) timed_out("ar_wait");
    tick();
    arvalid = 1'b0;
    chk("rvalid_after_ar", rvalid, 1);
    i = 0;
    n = 0;
    while (i <= len && n < 2000) begin
      rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      a = beat_addr(addr, burst, i);
      chk("rvalid", rvalid, 1);
      chk("rdata", rdata, beat_err(a, burst) ? 32'h0 : model_mem[widx(a)]);
      chk("rresp", rresp, beat_err(a, burst) ? 2'b10 : 2'b00);
      chk("rlast", rlast, i == len);
      chk("rid", rid, id);
      tick();
      if (rready) i++;
      n++;
    end
    rready = 1'b0;
    if (i <= len) timed_out("r_beats");
    chk("rvalid_drop", rvalid, 0);
    chk("arready_idle", arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] base;
    int len;
    logic [1:0] burst;

    reset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    repeat (2) tick();

    chk("rst_awready", awready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bid", bid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;
    tick();

    // Fill the whole RAM with one len=255 burst, then stream it back.
    for (int i = 0; i < 256; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
    write_burst(4'd1, 32'h0, 255, 2'b01, 0, 1'b0);
    read_burst(4'd1, 32'h0, 255, 2'b01, 1'b0);

    // Single beat
    wbuf_data[0] = 32'hDEADBEEF; wbuf_strb[0] = 4'hF;
    write_burst(4'd5, 32'h0, 0, 2'b01, 0, 1'b0);
    read_burst(4'd5, 32'h0, 0, 2'b01, 1'b0);

    // Four-beat INCR, streamed back with rready held
    for (int i = 0; i < 4; i++) begin wbuf_data[i] = 32'(i + 1); wbuf_strb[i] = 4'hF; end
    write_burst(4'd3, 32'h10, 3, 2'b01, 0, 1'b0);
    read_burst(4'd3, 32'h10, 3, 2'b01, 1'b0);

    // Partial strobe
    wbuf_data[0] = 32'hFFFFFFFF; wbuf_strb[0] = 4'hF;
    write_burst(4'd7, 32'h40, 0, 2'b01, 0, 1'b0);
    wbuf_data[0] = 32'h00000000; wbuf_strb[0] = 4'b0101;
    write_burst(4'd7, 32'h40, 0, 2'b01, 0, 1'b0);
    read_burst(4'd7, 32'h40, 0, 2'b01, 1'b0);

    // Backpressure on both response channels
    for (int i = 0; i < 4; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
    write_burst(4'd9, 32'h80, 3, 2'b01, 5, 1'b1);
    read_burst(4'd9, 32'h80, 3, 2'b01, 1'b1);

    // Out-of-range write and WRAP read
    wbuf_data[0] = 32'h12345678; wbuf_strb[0] = 4'hF;
    write_burst(4'd2, 32'(DEPTH * 4), 0, 2'b01, 0, 1'b0);
    read_burst(4'd2, 32'h0, 0, 2'b01, 1'b0);
    read_burst(4'd4, 32'h0, 0, 2'b10, 1'b0);

    // Randomized bursts, some crossing the top of the RAM
    for (int t = 0; t < 20; t++) begin
      base  = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      len   = $urandom_range(0, 7);
      burst = 2'($urandom_range(0, 1));
      for (int i = 0; i <= len; i++) begin
        wbuf_data[i] = $urandom;
        wbuf_strb[i] = 4'($urandom_range(0, 15));
      end
      write_burst(4'($urandom_range(0, 15)), base, len, burst, $urandom_range(0, 3), 1'b1);
      read_burst(4'($urandom_range(0, 15)), base, len, burst, 1'b1);
    end

    // Reset during beat 2 of a 4-beat write
    awid = 4'd6; awaddr = 32'h10; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("rst_mid_wready", wready, 1);
    wvalid = 1'b1; wdata = 32'hA5A50001; wstrb = 4'hF; wlast = 1'b0;
    model_mem[4] = 32'hA5A50001;
    tick();
    wdata = 32'hA5A50002;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_bvalid", bvalid, 0);
    chk("rst_mid_rvalid", rvalid, 0);
    chk("rst_mid_wready0", wready, 0);
    chk("rst_mid_awready", awready, 1);
    chk("rst_mid_arready", arready, 1);
    wvalid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    read_burst(4'd6, 32'h10, 3, 2'b01, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
